control_fsm: RTL and testbench

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/control_fsm.sv | 181 ++++++++++++++++++
 tb/tb_control_fsm.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle RV32I control unit.
// The state is registered; outputs are decoded from the current state.
// The FETCH, MEMREAD and MEMWRITE handshakes and the branch decision
// also use the live mem_ready/zero inputs, so these strobes land in the
// same cycle as the event that causes them.
// While reset is high, every output is forced to its reset value.
// Optional build macro: CTRL_ILLEGAL_TRAP_EN. When it is defined, an
// illegal encoding parks the FSM in HALT with illegal=1. When it is not
// defined, an illegal encoding acts as a NOP.
module control_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [2:0] alu_op,
   output logic       sign_op,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       mem_req,
   output logic       mem_write,
   output logic       reg_write,
   output logic       illegal
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI,
      S_AUIPC, S_HALT
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

`ifdef CTRL_ILLEGAL_TRAP_EN
   localparam state_t S_ILLEGAL = S_HALT;
`else
   localparam state_t S_ILLEGAL = S_FETCH;
`endif

   state_t state_q, state_d;

   // State register; reset always returns to FETCH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // Next-state decode.
   // JALR only computes its target into ALU-out.
   // It then reuses the JAL jump/link path (JAL, then ALUWB).
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_R:              state_d = S_EXEC_R;
               OP_I:              state_d = S_EXEC_I;
               OP_BRANCH:         state_d = (funct3[2:1] == 2'b01) ? S_ILLEGAL : S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               OP_LUI:            state_d = S_LUI;
               OP_AUIPC:          state_d = S_AUIPC;
               default:           state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
         S_MEMWB, S_ALUWB, S_BRANCH:          state_d = S_FETCH;
         S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC:  state_d = S_ALUWB;
         S_JAL:      state_d = S_ALUWB;
         S_JALR:     state_d = S_JAL;
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_FETCH;
      endcase
   end

   // Output decode from the current state.
   // While reset is high, the outputs are held at their reset values.
   always_comb begin
      alu_op     = '0;
      sign_op    = 1'b1;
      alu_src_a  = '0;
      alu_src_b  = '0;
      result_src = '0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               alu_src_b  = 2'b10;
               result_src = 2'b10;
               mem_req    = 1'b1;
               ir_write   = mem_ready;
               pc_write   = mem_ready;
            end
            S_DECODE: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b01;
            end
            S_MEMADR, S_JALR, S_LUI: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
               mem_req = 1'b1;
               adr_src = 1'b1;
            end
            S_MEMWRITE: begin
               mem_req   = 1'b1;
               mem_write = 1'b1;
               adr_src   = 1'b1;
            end
            S_MEMWB: begin
               result_src = 2'b01;
               reg_write  = 1'b1;
            end
            S_EXEC_R: begin
               alu_src_a = 2'b10;
               alu_op    = funct3;
               if (funct3 == 3'b000)      sign_op = ~funct7_5;
               else if (funct3 == 3'b101) sign_op = funct7_5;
            end
            S_EXEC_I: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b01;
               alu_op    = funct3;
               if (funct3 == 3'b101) sign_op = funct7_5;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BRANCH: begin
               alu_src_a = 2'b10;
               if (!funct3[2]) begin
                  sign_op  = 1'b0;
                  pc_write = funct3[0] ? ~zero : zero;
               end else begin
                  alu_op   = funct3[1] ? 3'b011 : 3'b010;
                  pc_write = funct3[0] ? zero : ~zero;
               end
            end
            S_JAL: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b10;
               pc_write  = 1'b1;
            end
            S_AUIPC: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b01;
            end
            default: ;
         endcase
      end
   end

`ifdef CTRL_ILLEGAL_TRAP_EN
   assign illegal = (state_q == S_HALT);
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed-vector bench for control_fsm.
// Each cycle, the bench drives inputs at the falling edge.
// It samples the packed outputs 1ns later.
module tb_control_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_5, zero, mem_ready;
   logic [2:0] alu_op;
   logic       sign_op;
   logic [1:0] alu_src_a, alu_src_b, result_src;
   logic       adr_src, ir_write, pc_write, mem_req, mem_write, reg_write, illegal;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   control_fsm dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
      .funct7_5(funct7_5), .zero(zero), .mem_ready(mem_ready),
      .alu_op(alu_op), .sign_op(sign_op), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .result_src(result_src), .adr_src(adr_src),
      .ir_write(ir_write), .pc_write(pc_write), .mem_req(mem_req),
      .mem_write(mem_write), .reg_write(reg_write), .illegal(illegal)
   );

   logic [16:0] obs;
   assign obs = {illegal, alu_op, sign_op, alu_src_a, alu_src_b, result_src,
                 adr_src, ir_write, pc_write, mem_req, mem_write, reg_write};

   // Expected output word, built from named fields.
   function automatic logic [16:0] v(input logic il, input logic [2:0] op, input logic s,
                                     input logic [1:0] a, input logic [1:0] b, input logic [1:0] r,
                                     input logic adr, input logic irw, input logic pcw,
                                     input logic req, input logic mw, input logic rw);
      return {il, op, s, a, b, r, adr, irw, pcw, req, mw, rw};
   endfunction

   task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %05h expected %05h", tag, got, exp);
      end
   endtask

   task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      opcode = op; funct3 = f3; funct7_5 = f7;
   endtask

   task automatic cyc(input string tag, input logic rdy, input logic z, input logic [16:0] exp);
      @(negedge clk);
      mem_ready = rdy; zero = z;
      #1 check(tag, obs, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; mem_ready = 1'b1;
      #1 check("reset", obs, v(0,0,1,0,0,0,0,0,0,0,0,0));
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   logic [16:0] F_RDY, F_WAIT, DEC, WB, HALT_V;

   initial begin
      F_RDY  = v(0,3'd0,1,2'd0,2'd2,2'd2,0,1,1,1,0,0);
      F_WAIT = v(0,3'd0,1,2'd0,2'd2,2'd2,0,0,0,1,0,0);
      DEC    = v(0,3'd0,1,2'd1,2'd1,2'd0,0,0,0,0,0,0);
      WB     = v(0,3'd0,1,2'd0,2'd0,2'd0,0,0,0,0,0,1);
      HALT_V = v(1,3'd0,1,2'd0,2'd0,2'd0,0,0,0,0,0,0);

      reset = 1'b0; mem_ready = 1'b0; zero = 1'b0;
      instr(7'b0110011, 3'b000, 1'b0);
      #2 reset = 1'b1;
      do_reset();

      // ADD x3,x1,x2
      cyc("add.fetch", 1, 0, F_RDY);
      cyc("add.dec",   1, 0, DEC);
      cyc("add.ex",    1, 0, v(0,3'd0,1,2'd2,2'd0,2'd0,0,0,0,0,0,0));
      cyc("add.wb",    1, 0, WB);
      // SUB
      instr(7'b0110011, 3'b000, 1'b1);
      cyc("sub.fetch", 1, 0, F_RDY);
      cyc("sub.dec",   1, 0, DEC);
      cyc("sub.ex",    1, 0, v(0,3'd0,0,2'd2,2'd0,2'd0,0,0,0,0,0,0));
      cyc("sub.wb",    1, 0, WB);
      // SRA, SRL
      instr(7'b0110011, 3'b101, 1'b1);
      cyc("sra.fetch", 1, 0, F_RDY);
      cyc("sra.dec",   1, 0, DEC);
      cyc("sra.ex",    1, 0, v(0,3'd5,1,2'd2,2'd0,2'd0,0,0,0,0,0,0));
      cyc("sra.wb",    1, 0, WB);
      instr(7'b0110011, 3'b101, 1'b0);
      cyc("srl.fetch", 1, 0, F_RDY);
      cyc("srl.dec",   1, 0, DEC);
      cyc("srl.ex",    1, 0, v(0,3'd5,0,2'd2,2'd0,2'd0,0,0,0,0,0,0));
      cyc("srl.wb",    1, 0, WB);
      // ADDI with instruction[30] set still adds
      instr(7'b0010011, 3'b000, 1'b1);
      cyc("addi.fetch", 1, 0, F_RDY);
      cyc("addi.dec",   1, 0, DEC);
      cyc("addi.ex",    1, 0, v(0,3'd0,1,2'd2,2'd1,2'd0,0,0,0,0,0,0));
      cyc("addi.wb",    1, 0, WB);
      // LW with 3 wait cycles in FETCH and in MEMREAD
      instr(7'b0000011, 3'b010, 1'b0);
      repeat (3) cyc("lw.fwait", 0, 0, F_WAIT);
      cyc("lw.fetch", 1, 0, F_RDY);
      cyc("lw.dec",   0, 0, DEC);
      cyc("lw.adr",   0, 0, v(0,3'd0,1,2'd2,2'd1,2'd0,0,0,0,0,0,0));
      repeat (3) cyc("lw.rwait", 0, 0, v(0,3'd0,1,2'd0,2'd0,2'd0,1,0,0,1,0,0));
      cyc("lw.read",  1, 0, v(0,3'd0,1,2'd0,2'd0,2'd0,1,0,0,1,0,0));
      cyc("lw.wb",    1, 0, v(0,3'd0,1,2'd0,2'd0,2'd1,0,0,0,0,0,1));
      // SW
      instr(7'b0100011, 3'b010, 1'b0);
      cyc("sw.fetch", 1, 0, F_RDY);
      cyc("sw.dec",   1, 0, DEC);
      cyc("sw.adr",   1, 0, v(0,3'd0,1,2'd2,2'd1,2'd0,0,0,0,0,0,0));
      cyc("sw.write", 1, 0, v(0,3'd0,1,2'd0,2'd0,2'd0,1,0,0,1,1,0));
      // BLT with zero=1 (not taken), then with zero=0 (taken)
      instr(7'b1100011, 3'b100, 1'b0);
      cyc("blt.fetch", 1, 0, F_RDY);
      cyc("blt.dec",   1, 0, DEC);
      cyc("blt.z1",    1, 1, v(0,3'd2,1,2'd2,2'd0,2'd0,0,0,0,0,0,0));
      cyc("blt.fetch", 1, 0, F_RDY);
      cyc("blt.dec",   1, 0, DEC);
      cyc("blt.z0",    1, 0, v(0,3'd2,1,2'd2,2'd0,2'd0,0,0,1,0,0,0));
      // BEQ taken, BNE not taken, BGEU taken (all with zero=1)
      instr(7'b1100011, 3'b000, 1'b0);
      cyc("beq.fetch", 1, 0, F_RDY);
      cyc("beq.dec",   1, 0, DEC);
      cyc("beq.z1",    1, 1, v(0,3'd0,0,2'd2,2'd0,2'd0,0,0,1,0,0,0));
      instr(7'b1100011, 3'b001, 1'b0);
      cyc("bne.fetch", 1, 0, F_RDY);
      cyc("bne.dec",   1, 0, DEC);
      cyc("bne.z1",    1, 1, v(0,3'd0,0,2'd2,2'd0,2'd0,0,0,0,0,0,0));
      instr(7'b1100011, 3'b111, 1'b0);
      cyc("bgeu.fetch", 1, 0, F_RDY);
      cyc("bgeu.dec",   1, 0, DEC);
      cyc("bgeu.z1",    1, 1, v(0,3'd3,1,2'd2,2'd0,2'd0,0,0,1,0,0,0));
      // JAL: jump in JAL, link in ALUWB
      instr(7'b1101111, 3'b000, 1'b0);
      cyc("jal.fetch", 1, 0, F_RDY);
      cyc("jal.dec",   1, 0, DEC);
      cyc("jal.jump",  1, 0, v(0,3'd0,1,2'd1,2'd2,2'd0,0,0,1,0,0,0));
      cyc("jal.link",  1, 0, WB);
      // JALR: rs1+imm, then the JAL path
      instr(7'b1100111, 3'b000, 1'b0);
      cyc("jalr.fetch", 1, 0, F_RDY);
      cyc("jalr.dec",   1, 0, DEC);
      cyc("jalr.tgt",   1, 0, v(0,3'd0,1,2'd2,2'd1,2'd0,0,0,0,0,0,0));
      cyc("jalr.jump",  1, 0, v(0,3'd0,1,2'd1,2'd2,2'd0,0,0,1,0,0,0));
      cyc("jalr.link",  1, 0, WB);
      // LUI, AUIPC
      instr(7'b0110111, 3'b000, 1'b0);
      cyc("lui.fetch", 1, 0, F_RDY);
      cyc("lui.dec",   1, 0, DEC);
      cyc("lui.ex",    1, 0, v(0,3'd0,1,2'd2,2'd1,2'd0,0,0,0,0,0,0));
      cyc("lui.wb",    1, 0, WB);
      instr(7'b0010111, 3'b000, 1'b0);
      cyc("auipc.fetch", 1, 0, F_RDY);
      cyc("auipc.dec",   1, 0, DEC);
      cyc("auipc.ex",    1, 0, v(0,3'd0,1,2'd1,2'd1,2'd0,0,0,0,0,0,0));
      cyc("auipc.wb",    1, 0, WB);
      cyc("next.fetch",  1, 0, F_RDY);
      do_reset();

      // Illegal encodings: opcode 0000000, then branch funct3 010
      for (int i = 0; i < 2; i++) begin
         if (i == 0) instr(7'b0000000, 3'b000, 1'b0);
         else        instr(7'b1100011, 3'b010, 1'b0);
         cyc("ill.fetch", 1, 0, F_RDY);
         cyc("ill.dec",   1, 0, DEC);
`ifdef CTRL_ILLEGAL_TRAP_EN
         repeat (3) cyc("ill.halt", 1, 1, HALT_V);
`else
         cyc("ill.nop", 1, 0, F_RDY);
`endif
         do_reset();
      end

      // Reset during a waiting store
      instr(7'b0100011, 3'b010, 1'b0);
      cyc("swr.fetch", 1, 0, F_RDY);
      cyc("swr.dec",   0, 0, DEC);
      cyc("swr.adr",   0, 0, v(0,3'd0,1,2'd2,2'd1,2'd0,0,0,0,0,0,0));
      cyc("swr.wait",  0, 0, v(0,3'd0,1,2'd0,2'd0,2'd0,1,0,0,1,1,0));
      #1 reset = 1'b1;
      #1 check("swr.rst", obs, v(0,3'd0,1,2'd0,2'd0,2'd0,0,0,0,0,0,0));
      @(posedge clk);
      #1 reset = 1'b0;
      cyc("swr.fwait", 0, 0, F_WAIT);
      cyc("swr.fetch", 1, 0, F_RDY);
      cyc("swr.dec",   1, 0, DEC);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
